// File: rtl/mixer_pkg.sv
// Shared FSM state type, accumulator sizing and output saturation for the track mixer.
// Pure declarations; no timing or flow-control behaviour of its own.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } mix_state_t;

  // Widest intermediate the saturation helper accepts; lanes sign-extend into it.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clip;
  } sat_t;

  function automatic int acc_width(input int width, input int gain_width, input int num_tracks);
    return width + gain_width + 1 + $clog2(num_tracks);
  endfunction

  function automatic sat_t saturate(input logic signed [SAT_W-1:0] acc, input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t                    res;
    hi        = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo        = -hi - 64'sd1;
    res.value = acc;
    res.clip  = 1'b0;
    if (acc > hi) begin
      res.value = hi;
      res.clip  = 1'b1;
    end else if (acc < lo) begin
      res.value = lo;
      res.clip  = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mixer_lane.sv
// One stereo lane: serial multiply-accumulate, floor shift, saturate into the output register.
// Result registered on load_in; no backpressure, sequencing comes from the parent FSM.
module mixer_lane
  import mixer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int GAIN_WIDTH = 8,
  parameter int NUM_TRACKS = 4,
  parameter int GAIN_SHIFT = 7
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clear_in,
  input  logic                    accum_in,
  input  logic                    audible_in,
  input  logic                    load_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic [GAIN_WIDTH-1:0]   gain_in,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    clip_out
);

  localparam int ACC_W  = acc_width(WIDTH, GAIN_WIDTH, NUM_TRACKS);
  localparam int PROD_W = WIDTH + GAIN_WIDTH + 1;

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  sat_t                     sat;

  // Gain is zero-extended so the multiply stays signed and 2^GAIN_WIDTH-1 is reachable.
  assign product = PROD_W'(sample_in) * PROD_W'($signed({1'b0, gain_in}));
  assign shifted = acc >>> GAIN_SHIFT;
  assign sat     = saturate(SAT_W'(shifted), WIDTH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc      <= '0;
      data_out <= '0;
      clip_out <= 1'b0;
    end else begin
      clip_out <= 1'b0;
      if (clear_in) begin
        acc <= '0;
      end else if (accum_in && audible_in) begin
        acc <= acc + ACC_W'(product);
      end
      if (load_in) begin
        data_out <= WIDTH'(sat.value);
        clip_out <= sat.clip;
      end
    end
  end

endmodule

// File: rtl/track_mixer.sv
// N-track stereo mixer: snapshot a frame, accumulate one track per cycle, output NUM_TRACKS+2 cycles later.
// No backpressure; a frame request while busy is dropped and flagged on overrun_out.
module track_mixer
  import mixer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 4,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_SHIFT = 7,
  localparam int SEL_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             sample_valid_in,
  input  logic [NUM_TRACKS*WIDTH-1:0]      data_l_in,
  input  logic [NUM_TRACKS*WIDTH-1:0]      data_r_in,
  input  logic [NUM_TRACKS*GAIN_WIDTH-1:0] gain_in,
  input  logic [NUM_TRACKS-1:0]            mute_in,
  input  logic                             solo_enable_in,
  input  logic [SEL_W-1:0]                 solo_sel_in,
  output logic signed [WIDTH-1:0]          data_l_out,
  output logic signed [WIDTH-1:0]          data_r_out,
  output logic                             valid_out,
  output logic                             busy_out,
  output logic                             clip_l_out,
  output logic                             clip_r_out,
  output logic                             overrun_out
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_TRACKS - 1);

  mix_state_t state_q, state_d;
  logic [SEL_W-1:0] idx;
  logic             start, accum, load, audible;

  logic signed [WIDTH-1:0] snap_l    [NUM_TRACKS];
  logic signed [WIDTH-1:0] snap_r    [NUM_TRACKS];
  logic [GAIN_WIDTH-1:0]   snap_gain [NUM_TRACKS];
  logic [NUM_TRACKS-1:0]   snap_mute;
  logic                    snap_solo_en;
  logic [SEL_W-1:0]        snap_solo_sel;

  // The valid_out cycle still counts as busy, so a request landing on it is an overrun.
  assign busy_out = (state_q != IDLE) || valid_out;
  assign audible  = snap_solo_en ? (idx == snap_solo_sel) : !snap_mute[idx];

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    accum   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid_in && !valid_out) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        accum = 1'b1;
        if (idx == LAST_IDX) state_d = OUTPUT;
      end
      OUTPUT: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      idx           <= '0;
      valid_out     <= 1'b0;
      overrun_out   <= 1'b0;
      snap_mute     <= '0;
      snap_solo_en  <= 1'b0;
      snap_solo_sel <= '0;
    end else begin
      state_q     <= state_d;
      valid_out   <= load;
      overrun_out <= sample_valid_in && busy_out;
      if (start) begin
        idx           <= '0;
        snap_mute     <= mute_in;
        snap_solo_en  <= solo_enable_in;
        snap_solo_sel <= solo_sel_in;
      end else if (accum) begin
        idx <= idx + SEL_W'(1);
      end
    end
  end

  // Sample and gain snapshot needs no reset: it is only read after a start loads it.
  always_ff @(posedge clk_in) begin
    if (start) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        snap_l[t]    <= data_l_in[t*WIDTH +: WIDTH];
        snap_r[t]    <= data_r_in[t*WIDTH +: WIDTH];
        snap_gain[t] <= gain_in[t*GAIN_WIDTH +: GAIN_WIDTH];
      end
    end
  end

  mixer_lane #(
    .WIDTH     (WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .NUM_TRACKS(NUM_TRACKS),
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_lane_l (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (start),
    .accum_in  (accum),
    .audible_in(audible),
    .load_in   (load),
    .sample_in (snap_l[idx]),
    .gain_in   (snap_gain[idx]),
    .data_out  (data_l_out),
    .clip_out  (clip_l_out)
  );

  mixer_lane #(
    .WIDTH     (WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH),
    .NUM_TRACKS(NUM_TRACKS),
    .GAIN_SHIFT(GAIN_SHIFT)
  ) u_lane_r (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clear_in  (start),
    .accum_in  (accum),
    .audible_in(audible),
    .load_in   (load),
    .sample_in (snap_r[idx]),
    .gain_in   (snap_gain[idx]),
    .data_out  (data_r_out),
    .clip_out  (clip_r_out)
  );

endmodule

// File: doc/track_mixer.md
Name: track_mixer

Overview:
Parametrised N-track stereo mixer that sums per-track audio into one stereo bus for the i2s_transmitter path, replacing the fixed single-chain routing. Each track has an unsigned gain, a mute bit and a global solo select. It runs on clk_22 and processes one frame per sample_valid_in pulse. Tracks are accumulated serially, one per cycle, with a single multiplier per channel.

Parameters:
WIDTH, 16, signed sample width of inputs and outputs
NUM_TRACKS, 4, number of stereo tracks (>=1)
GAIN_WIDTH, 8, unsigned per-track gain width
GAIN_SHIFT, 7, arithmetic right shift after accumulation; gain 2^GAIN_SHIFT = unity

Ports:
clk_in  input  1  system clock (clk_22)
rst_in  input  1  synchronous active-high reset
sample_valid_in  input  1  one-cycle pulse: a new frame is present on data_l_in/data_r_in
data_l_in  input  NUM_TRACKS*WIDTH  packed signed left samples; track t at [t*WIDTH +: WIDTH]
data_r_in  input  NUM_TRACKS*WIDTH  packed signed right samples, same packing
gain_in  input  NUM_TRACKS*GAIN_WIDTH  packed unsigned per-track gains
mute_in  input  NUM_TRACKS  1 = track silenced
solo_enable_in  input  1  1 = only the solo track is audible
solo_sel_in  input  $clog2(NUM_TRACKS) (min 1)  solo track index
data_l_out  output  WIDTH  mixed left sample, held between frames
data_r_out  output  WIDTH  mixed right sample, held between frames
valid_out  output  1  one-cycle pulse when outputs update
busy_out  output  1  high while a frame is in progress
clip_l_out  output  1  one-cycle pulse with valid_out if left saturated
clip_r_out  output  1  one-cycle pulse with valid_out if right saturated
overrun_out  output  1  one-cycle pulse when sample_valid_in arrives while busy

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high. On reset, all outputs are 0, the FSM goes to IDLE and the accumulators are cleared.
- FSM states are IDLE, ACCUM and OUTPUT.
- IDLE:
  - On sample_valid_in, register all data, gain, mute and solo inputs into a frame snapshot.
  - Clear both accumulators, set the track index to 0 and go to ACCUM.
  - Later input changes do not affect the current frame.
- ACCUM:
  - Each cycle, add the product for track idx to each lane accumulator; idx increments.
  - Product = signed sample * signed {1'b0, gain}.
  - Track audible = solo_enable ? (idx == solo_sel) : !mute[idx]. Solo overrides mute.
  - An inaudible track adds 0.
  - After idx == NUM_TRACKS-1, go to OUTPUT.
- Accumulator width: WIDTH + GAIN_WIDTH + 1 + $clog2(NUM_TRACKS). No internal overflow.
- OUTPUT:
  - result = acc >>> GAIN_SHIFT (arithmetic; floor, so -1 >>> 7 = -1).
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and register into data_*_out.
  - Pulse valid_out. Pulse clip_* if that lane clamped.
  - Return to IDLE.
- Latency: valid_out is asserted NUM_TRACKS+2 cycles after the sample_valid_in cycle (6 for defaults).
- busy_out is high from the cycle after sample_valid_in through the valid_out cycle inclusive.
- Overrun: sample_valid_in while busy_out=1 is ignored. overrun_out pulses the next cycle and the current frame completes unaffected.
- sample_valid_in in the same cycle as valid_out: this is overrun and is ignored.
- solo_sel >= NUM_TRACKS with solo_enable=1: every track is inaudible and the output is 0.
- Reset mid-frame: the frame is abandoned, no valid_out pulse, outputs go to 0.

Decomposition:
- mixer_pkg holds:
  - typedef enum for the FSM states;
  - function acc_width(WIDTH, GAIN_WIDTH, NUM_TRACKS);
  - function saturate(acc, WIDTH) returning a clamped value plus a clip flag.
- Sub-module mixer_lane: one accumulator, multiplier, shift and saturation. It is instantiated twice (L, R) and is driven by the shared FSM/index in track_mixer.

Test Plan:
1. Defaults; L = {1000, 2000, -500, 0}, all gains 128, no mute/solo; pulse valid -> data_l_out = 2500 exactly 6 cycles later, valid_out high for 1 cycle, busy_out high 6 cycles.
2. Track0 only (others muted), sample 1000:
   - gain 64 -> 500;
   - gain 255 -> 1992 (255000 >>> 7).
   R = -1 with gain 1 -> -1 (floor).
3. All four L = 30000, gain 128 -> data_l_out = 32767 and clip_l_out pulses. All four = -30000 -> -32768 and clip_l_out pulses. R unclipped -> clip_r_out stays 0.
4. mute = 4'b0100, solo_enable = 1, solo_sel = 2, L = {100, 200, 300, 400}, gains 128 -> 300. solo_sel = 5 is not representable at the default width; with NUM_TRACKS = 3 and solo_sel = 3 -> 0.
5. Second sample_valid_in 2 cycles after the first:
   - overrun_out pulses once;
   - only one valid_out;
   - the output equals the first frame's mix.
   Changing inputs mid-frame -> no effect on the result.
6. Assert rst_in at cycle 3 of a frame -> outputs 0, no valid_out. The next frame mixes correctly with 6-cycle latency.
